// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage: either a two-entry skid buffer with registered in_ready,
// or a single entry whose in_ready passes through from out_ready.
module pipe_stage #(
  parameter int unsigned   DW      = 32,
  parameter logic [255:0]  RST_VAL = 32'h00000013,
  parameter int unsigned   SKID    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occ
);

  localparam logic [DW-1:0] LP_RST_VAL = RST_VAL[DW-1:0];

  logic          r_live;
  logic          r_m_vld;
  logic [DW-1:0] r_m_dat;
  logic          w_s_vld;
  logic [DW-1:0] w_s_dat;
  logic          w_acc;
  logic          w_rel;

  assign w_acc = in_valid && in_ready;
  assign w_rel = r_m_vld && out_ready && !flush;

  // r_live keeps in_ready low during reset without routing rst into the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= 1'b0;
      r_m_vld <= 1'b0;
      r_m_dat <= LP_RST_VAL;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_m_vld <= 1'b0;
        r_m_dat <= LP_RST_VAL;
      end else if (!r_m_vld) begin
        if (w_acc) begin
          r_m_vld <= 1'b1;
          r_m_dat <= in_data;
        end
      end else if (w_s_vld) begin
        if (w_rel) r_m_dat <= w_s_dat;
      end else if (w_rel) begin
        if (w_acc) r_m_dat <= in_data;
        else       r_m_vld <= 1'b0;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic          r_s_vld;
      logic [DW-1:0] r_s_dat;

      // S only fills when M is held and cannot drain this cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s_vld <= 1'b0;
          r_s_dat <= LP_RST_VAL;
        end else if (flush) begin
          r_s_vld <= 1'b0;
          r_s_dat <= LP_RST_VAL;
        end else if (r_s_vld) begin
          if (w_rel) r_s_vld <= 1'b0;
        end else if (r_m_vld && w_acc && !w_rel) begin
          r_s_vld <= 1'b1;
          r_s_dat <= in_data;
        end
      end

      assign w_s_vld  = r_s_vld;
      assign w_s_dat  = r_s_dat;
      assign in_ready = r_live && !r_s_vld && !flush;
    end else begin : g_pass
      assign w_s_vld  = 1'b0;
      assign w_s_dat  = '0;
      assign in_ready = r_live && (!r_m_vld || out_ready) && !flush;
    end
  endgenerate

  assign out_valid = r_m_vld;
  assign out_data  = r_m_vld ? r_m_dat : LP_RST_VAL;
  assign occ       = {1'b0, r_m_vld} + {1'b0, w_s_vld};

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed vector table, hand-written corner sequences,
// and random traffic for both modes against a queue-based model.
module tb_pipe_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;

  logic        s1_fl, s1_iv, s1_or, s1_ir, s1_ov;
  logic [31:0] s1_d, s1_od;
  logic [1:0]  s1_occ;
  logic        s0_fl, s0_iv, s0_or, s0_ir, s0_ov;
  logic [31:0] s0_d, s0_od;
  logic [1:0]  s0_occ;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        hold[2];
  logic [31:0] held[2];

  always #5 clk = ~clk;

  pipe_stage #(.DW(32), .RST_VAL(32'h13), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(s1_fl),
    .in_valid(s1_iv), .in_ready(s1_ir), .in_data(s1_d),
    .out_valid(s1_ov), .out_ready(s1_or), .out_data(s1_od), .occ(s1_occ)
  );

  pipe_stage #(.DW(32), .RST_VAL(32'h13), .SKID(0)) u_pass (
    .clk(clk), .rst(rst), .flush(s0_fl),
    .in_valid(s0_iv), .in_ready(s0_ir), .in_data(s0_d),
    .out_valid(s0_ov), .out_ready(s0_or), .out_data(s0_od), .occ(s0_occ)
  );

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic ov, input logic [31:0] od,
                              input logic [1:0] occ, input logic ir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drv1(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    s1_fl = fl; s1_iv = iv; s1_d = d; s1_or = ordy;
  endtask

  task automatic drv0(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    s0_fl = fl; s0_iv = iv; s0_d = d; s0_or = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Model: held payloads are a FIFO; outputs and readiness follow from its depth.
  task automatic mcheck(input int m, input int cyc, input logic fl, input logic ordy,
                        input logic ir, input logic ov, input logic [31:0] od,
                        input logic [1:0] occ, output logic exp_ir);
    int          n;
    logic [31:0] head;
    n    = (m == 1) ? q1.size() : q0.size();
    head = (n == 0) ? NOP : ((m == 1) ? q1[0] : q0[0]);
    if (m == 1) exp_ir = (n < 2) && !fl;
    else        exp_ir = ((n == 0) || ordy) && !fl;
    chk($sformatf("rnd_s%0d_c%0d_ir", m, cyc), {31'd0, ir}, {31'd0, exp_ir});
    chk($sformatf("rnd_s%0d_c%0d_ov", m, cyc), {31'd0, ov}, {31'd0, n != 0});
    chk($sformatf("rnd_s%0d_c%0d_od", m, cyc), od, head);
    chk($sformatf("rnd_s%0d_c%0d_occ", m, cyc), {30'd0, occ}, n);
    if (hold[m]) chk($sformatf("rnd_s%0d_c%0d_stable", m, cyc), od, held[m]);
  endtask

  task automatic mupdate(input int m, input logic fl, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic exp_ir, input logic [31:0] od);
    int n;
    n = (m == 1) ? q1.size() : q0.size();
    hold[m] = (n != 0) && !ordy && !fl;
    held[m] = od;
    if (fl) begin
      if (m == 1) q1.delete(); else q0.delete();
    end else begin
      if ((n != 0) && ordy) begin
        if (m == 1) void'(q1.pop_front()); else void'(q0.pop_front());
      end
      if (iv && exp_ir) begin
        if (m == 1) q1.push_back(d); else q0.push_back(d);
      end
    end
  endtask

  initial begin
    logic        fl1, iv1, or1, fl0, iv0, or0, eir1, eir0;
    logic [31:0] d1, d0;

    // Streaming 1..8, then skid fill/drain 0xA/0xB/0xC, then flush with occ=2.
    vt[0] = mk(0, 1, 32'h01, 1, 0, NOP,   0, 1);
    for (int unsigned k = 1; k < 8; k++)
      vt[k] = mk(0, 1, k + 1, 1, 1, k, 1, 1);
    vt[8]  = mk(0, 0, 32'h00, 1, 1, 32'h08, 1, 1);
    vt[9]  = mk(0, 0, 32'h00, 1, 0, NOP,    0, 1);
    vt[10] = mk(0, 1, 32'h0A, 0, 0, NOP,    0, 1);
    vt[11] = mk(0, 1, 32'h0B, 0, 1, 32'h0A, 1, 1);
    vt[12] = mk(0, 1, 32'h0C, 0, 1, 32'h0A, 2, 0);
    vt[13] = mk(0, 1, 32'h0C, 1, 1, 32'h0A, 2, 0);
    vt[14] = mk(0, 1, 32'h0C, 1, 1, 32'h0B, 1, 1);
    vt[15] = mk(0, 0, 32'h00, 0, 1, 32'h0C, 1, 1);
    vt[16] = mk(0, 1, 32'h0D, 0, 1, 32'h0C, 1, 1);
    vt[17] = mk(1, 1, 32'h0E, 1, 1, 32'h0C, 2, 0);
    vt[18] = mk(0, 0, 32'h00, 0, 0, NOP,    0, 1);
    vt[19] = mk(0, 0, 32'h00, 0, 0, NOP,    0, 1);

    hold[0] = 1'b0; hold[1] = 1'b0;
    held[0] = '0;   held[1] = '0;
    drv1(0, 0, 0, 0);
    drv0(0, 0, 0, 0);
    rst = 1'b0;

    #3;
    chk("rst_s1_ov",  {31'd0, s1_ov},  0);
    chk("rst_s1_od",  s1_od,           NOP);
    chk("rst_s1_occ", {30'd0, s1_occ}, 0);
    chk("rst_s1_ir",  {31'd0, s1_ir},  0);
    chk("rst_s0_ov",  {31'd0, s0_ov},  0);
    chk("rst_s0_od",  s0_od,           NOP);
    chk("rst_s0_occ", {30'd0, s0_occ}, 0);
    chk("rst_s0_ir",  {31'd0, s0_ir},  0);
    #9 rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 20; i++) begin
      drv1(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_ov", i),  {31'd0, s1_ov},  {31'd0, vt[i].ov});
      chk($sformatf("vec%0d_od", i),  s1_od,           vt[i].od);
      chk($sformatf("vec%0d_occ", i), {30'd0, s1_occ}, {30'd0, vt[i].occ});
      chk($sformatf("vec%0d_ir", i),  {31'd0, s1_ir},  {31'd0, vt[i].ir});
      next_cycle();
    end
    drv1(0, 0, 0, 0);

    // Pass-through mode: release and accept in the same cycle.
    drv0(0, 1, 32'h31, 0);
    @(negedge clk);
    chk("pass_a_ir", {31'd0, s0_ir}, 1);
    chk("pass_a_ov", {31'd0, s0_ov}, 0);
    next_cycle();
    drv0(0, 1, 32'h32, 1);
    @(negedge clk);
    chk("pass_b_ir",  {31'd0, s0_ir},  1);
    chk("pass_b_od",  s0_od,           32'h31);
    chk("pass_b_occ", {30'd0, s0_occ}, 1);
    next_cycle();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    chk("pass_c_od",  s0_od,           32'h32);
    chk("pass_c_occ", {30'd0, s0_occ}, 1);
    chk("pass_c_ir",  {31'd0, s0_ir},  0);
    next_cycle();

    // Asynchronous reset while the skid stage holds two entries.
    drv1(0, 1, 32'h21, 0);
    next_cycle();
    drv1(0, 1, 32'h22, 0);
    next_cycle();
    drv1(0, 0, 0, 0);
    chk("mid_pre_occ", {30'd0, s1_occ}, 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ov",   {31'd0, s1_ov},  0);
    chk("mid_rst_od",   s1_od,           NOP);
    chk("mid_rst_occ",  {30'd0, s1_occ}, 0);
    chk("mid_rst_ir",   {31'd0, s1_ir},  0);
    chk("mid_rst_s0ov", {31'd0, s0_ov},  0);
    @(negedge clk);
    #2 rst = 1'b1;
    next_cycle();
    drv1(0, 1, 32'h55, 1);
    @(negedge clk);
    chk("post_rst_ir", {31'd0, s1_ir}, 1);
    chk("post_rst_ov", {31'd0, s1_ov}, 0);
    next_cycle();
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_ov1", {31'd0, s1_ov},  1);
    chk("post_rst_od",  s1_od,           32'h55);
    chk("post_rst_occ", {30'd0, s1_occ}, 1);
    next_cycle();

    drv1(1, 0, 0, 0);
    drv0(1, 0, 0, 0);
    next_cycle();

    for (int c = 0; c < 10000; c++) begin
      fl1 = ($urandom_range(0, 63) == 0);
      iv1 = ($urandom_range(0, 3) != 0);
      or1 = ($urandom_range(0, 3) != 0);
      d1  = $urandom;
      fl0 = ($urandom_range(0, 63) == 0);
      iv0 = ($urandom_range(0, 3) != 0);
      or0 = ($urandom_range(0, 3) != 0);
      d0  = $urandom;
      drv1(fl1, iv1, d1, or1);
      drv0(fl0, iv0, d0, or0);
      @(negedge clk);
      mcheck(1, c, fl1, or1, s1_ir, s1_ov, s1_od, s1_occ, eir1);
      mcheck(0, c, fl0, or0, s0_ir, s0_ov, s0_od, s0_occ, eir0);
      mupdate(1, fl1, iv1, d1, or1, eir1, s1_od);
      mupdate(0, fl0, iv0, d0, or0, eir0, s0_od);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The module SHALL have parameter DW, default 32, giving the payload width in bits (legal range 1..256).
REQ-002 The module SHALL have parameter RST_VAL, default 32'h00000013 (NOP), giving the payload value driven on out_data while the stage is empty; it SHALL be truncated or zero-extended to DW.
REQ-003 The module SHALL have parameter SKID, default 1, selecting the mode: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with pass-through in_ready.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 The module SHALL have port in_valid, input, 1 bit: the upstream payload is valid.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the stage accepts a payload this cycle.
REQ-009 The module SHALL have port in_data, input, DW bits: the upstream payload.
REQ-010 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-012 The module SHALL have port out_data, output, DW bits: the head payload.
REQ-013 The module SHALL have port occ, output, 2 bits: the number of held entries (0..2).

Function
REQ-014 An accept SHALL occur when in_valid && in_ready; a release SHALL occur when out_valid && out_ready.
REQ-015 The state SHALL be a main entry M (valid bit plus data) and, when SKID=1, a skid entry S; out_valid SHALL equal M.valid, and out_data SHALL equal M.data when M is valid, else RST_VAL.
REQ-016 Latency SHALL be exactly 1 cycle: a payload accepted into an empty stage appears on out_data at the next rising edge.
REQ-017 When out_valid=1 and out_ready=0, out_valid and out_data SHALL hold stable until release or flush.
REQ-018 When SKID=1, in_ready SHALL be !S.valid && !flush, driven from state with no combinational path from out_ready or in_valid.
REQ-019 When SKID=1, the next state SHALL be:
- M empty, accept: M <= in.
- M full, release, accept: M <= in.
- M full, no release, accept: S <= in.
- M full, S full, release: M <= S, S empty.
- M full, S empty, release, no accept: M empty.
- Otherwise: hold.
REQ-020 When SKID=1, payload order SHALL be preserved and sustained throughput SHALL be one payload per cycle with in_valid=out_ready=1.
REQ-021 When SKID=0, in_ready SHALL be (!M.valid || out_ready) && !flush, S SHALL NOT exist, and occ[1] SHALL be 0.
REQ-022 When SKID=0, accept SHALL load M; release without accept SHALL empty M.
REQ-023 occ SHALL equal M.valid + S.valid at all times, and S.valid=1 SHALL imply M.valid=1.
REQ-024 Flush SHALL override everything: the next edge SHALL clear M.valid and S.valid, set the data registers to RST_VAL, perform no accept (in_ready=0 that cycle), and drop any release in that cycle.
REQ-025 Flush SHALL take priority over simultaneous in_valid, out_ready, or a full stage; in_ready SHALL be 1 in the cycle after flush is deasserted.

Reset
REQ-026 While rst=0, asynchronously and regardless of clk: M.valid=0, S.valid=0, data registers=RST_VAL, out_valid=0, out_data=RST_VAL, occ=0, in_ready=0.
REQ-027 in_ready SHALL rise in the first cycle after rst deasserts; reset asserted mid-transfer SHALL discard all held payloads without producing a release.
REQ-028 Reset deassertion SHALL be synchronised externally; the module SHALL NOT require a clock edge to enter reset.

Verification
REQ-029 SKID=1, DW=32: stream 8'h01..8'h08 with out_ready=1 -> out_data 1..8 on consecutive cycles one cycle after input, occ=1 throughout, in_ready=1 throughout.
REQ-030 SKID=1: accept 0xA, then hold out_ready=0 while offering 0xB, 0xC -> 0xB accepted, occ=2, in_ready=0, 0xC held upstream; raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplication.
REQ-031 SKID=0: M full with out_ready=1 and in_valid=1 in the same cycle -> in_ready=1, release and accept both occur, occ stays 1.
REQ-032 Flush with occ=2 and in_valid=1 -> next cycle occ=0, out_valid=0, out_data=RST_VAL (32'h13), the offered payload is not accepted.
REQ-033 Assert rst=0 between clock edges with occ=2 -> outputs change immediately to reset values; after release, the first accepted payload appears after 1 cycle.
REQ-034 Random valid/ready traffic for 10k cycles in both SKID modes against a FIFO scoreboard -> zero ordering or data mismatches, and out_data stable whenever out_valid=1 and out_ready=0.
